// File: rtl/fetch_sched_pkg.sv
// Shared types and constants for the multithreaded fetch scheduler.
package fetch_sched_pkg;

   localparam int NTHREADS = 4;
   localparam int TID_W = $clog2(NTHREADS);
   localparam int PC_W = 32;
   localparam logic [PC_W-1:0] BOOT_PC = 32'h0000_1000;
   localparam int INSTR_BYTES = 4;

   typedef logic [TID_W-1:0] threadid_t;
   typedef logic [PC_W-1:0] pc_t;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      WAIT_TLB  = 2'd1,
      WAIT_FILL = 2'd2
   } fetch_state_t;

   // One outstanding fetch awaiting the hazard unit's verdict.
   typedef struct packed {
      logic      valid;
      logic      killed;
      threadid_t thread;
      pc_t       pc;
      logic      itlb_miss;
      logic      icache_miss;
   } inflight_t;

endpackage

// File: rtl/fetch_sched_if.sv
// Fetch-side bundle between the scheduler and its environment
// (I-TLB/I-cache, hazard unit, refill engines, execute redirect).
interface fetch_sched_if;
   import fetch_sched_pkg::*;

   logic [NTHREADS-1:0] thread_en;
   logic                fetch_valid;
   threadid_t           fetch_thread;
   pc_t                 fetch_pc;
   logic                itlb_miss;
   logic                icache_miss;
   logic                hzu_isvalid;
   logic                tlb_done;
   threadid_t           tlb_thread;
   logic                fill_done;
   threadid_t           fill_thread;
   logic                redirect_valid;
   threadid_t           redirect_thread;
   pc_t                 redirect_pc;

   // Scheduler side: drives the fetch, consumes everything else.
   modport master (
      output fetch_valid, fetch_thread, fetch_pc,
      input  thread_en, itlb_miss, icache_miss, hzu_isvalid,
             tlb_done, tlb_thread, fill_done, fill_thread,
             redirect_valid, redirect_thread, redirect_pc
   );

   // Environment side.
   modport slave (
      input  fetch_valid, fetch_thread, fetch_pc,
      output thread_en, itlb_miss, icache_miss, hzu_isvalid,
             tlb_done, tlb_thread, fill_done, fill_thread,
             redirect_valid, redirect_thread, redirect_pc
   );

endinterface

// File: rtl/fetch_sched_rr_arbiter.sv
// Round-robin picker: first requester strictly after ptr, wrapping; ptr itself is last.
module rr_arbiter #(
   parameter int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         grant_valid,
   output logic [W-1:0] grant_idx
);

   logic [W-1:0] idx;

   // Rotating priority scan starting at ptr+1; index width truncation does the wrap.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      idx         = '0;
      for (int i = 1; i <= N; i++) begin
         idx = ptr + W'(i);
         if (!grant_valid && req[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = idx;
         end
      end
   end

endmodule

// File: rtl/fetch_sched.sv
// Multithreaded fetch scheduler.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   RUN       | eligible for issue (unless in flight/disabled)
//   WAIT_TLB  | parked until tlb_done names this thread
//   WAIT_FILL | parked until fill_done names this thread
module fetch_sched
   import fetch_sched_pkg::*;
(
   input logic           clk,
   input logic           rst,
   fetch_sched_if.master bus
);

   fetch_state_t        state     [NTHREADS];
   fetch_state_t        state_nxt [NTHREADS];
   pc_t                 pc        [NTHREADS];
   pc_t                 pc_nxt    [NTHREADS];
   inflight_t           infl, infl_nxt;
   threadid_t           ptr, ptr_nxt;
   logic [NTHREADS-1:0] eligible;
   logic                grant_valid;
   threadid_t           grant_idx;
   logic                issue;
   logic                kill_cur;

   // A thread may issue only when running, enabled, and not already awaiting a verdict.
   always_comb begin
      eligible = '0;
      for (int t = 0; t < NTHREADS; t++) begin
         eligible[t] = (state[t] == RUN) && bus.thread_en[t]
                       && !(infl.valid && infl.thread == threadid_t'(t));
      end
   end

   rr_arbiter #(.N(NTHREADS)) u_arb (
      .req         (eligible),
      .ptr         (ptr),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // Per-thread state, PCs, in-flight record and round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int t = 0; t < NTHREADS; t++) begin
            state[t] <= RUN;
            pc[t]    <= BOOT_PC;
         end
         infl <= '0;
         ptr  <= threadid_t'(NTHREADS - 1);
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         infl  <= infl_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // Next state: speculative increment, rewind/park, wake-up, then redirect last so it wins.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      infl_nxt  = '0;
      ptr_nxt   = ptr;
      kill_cur  = infl.killed
                  || (bus.redirect_valid && bus.redirect_thread == infl.thread);

      if (issue) begin
         pc_nxt[grant_idx]    = pc[grant_idx] + pc_t'(INSTR_BYTES);
         ptr_nxt              = grant_idx;
         infl_nxt.valid       = 1'b1;
         infl_nxt.killed      = bus.redirect_valid && bus.redirect_thread == grant_idx;
         infl_nxt.thread      = grant_idx;
         infl_nxt.pc          = pc[grant_idx];
         infl_nxt.itlb_miss   = bus.itlb_miss;
         infl_nxt.icache_miss = bus.icache_miss;
      end

      if (infl.valid && !kill_cur && !bus.hzu_isvalid) begin
         pc_nxt[infl.thread] = infl.pc;
         if (infl.itlb_miss) begin
            state_nxt[infl.thread] = WAIT_TLB;
         end else if (infl.icache_miss) begin
            state_nxt[infl.thread] = WAIT_FILL;
         end
      end

      if (bus.tlb_done && state[bus.tlb_thread] == WAIT_TLB) begin
         state_nxt[bus.tlb_thread] = RUN;
      end
      if (bus.fill_done && state[bus.fill_thread] == WAIT_FILL) begin
         state_nxt[bus.fill_thread] = RUN;
      end

      if (bus.redirect_valid) begin
         pc_nxt[bus.redirect_thread]    = bus.redirect_pc;
         state_nxt[bus.redirect_thread] = RUN;
      end
   end

   // Fetch outputs straight from current state; suppressed while reset is held.
   always_comb begin
      issue            = grant_valid && !rst;
      bus.fetch_valid  = issue;
      bus.fetch_thread = issue ? grant_idx : '0;
      bus.fetch_pc     = issue ? pc[grant_idx] : pc[0];
   end

endmodule

// File: tb/tb_fetch_sched.sv
// Directed bench for fetch_sched: round-robin order, lone-thread cadence,
// park/wake on misses, replay, redirect versus rewind, PC wrap.
module tb_fetch_sched;
   import fetch_sched_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   fetch_sched_if bus ();

   fetch_sched dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to the next low phase and return all pulse inputs to idle.
   task automatic cyc();
      @(negedge clk);
      bus.hzu_isvalid     = 1'b1;
      bus.itlb_miss       = 1'b0;
      bus.icache_miss     = 1'b0;
      bus.tlb_done        = 1'b0;
      bus.tlb_thread      = '0;
      bus.fill_done       = 1'b0;
      bus.fill_thread     = '0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_thread = '0;
      bus.redirect_pc     = '0;
   endtask

   task automatic expect_fetch(input string tag, input logic v, input int t, input logic [31:0] p);
      #1;
      chk({tag, "_valid"}, 32'(bus.fetch_valid), 32'(v));
      if (v) begin
         chk({tag, "_thread"}, 32'(bus.fetch_thread), 32'(t));
         chk({tag, "_pc"}, bus.fetch_pc, p);
      end
   endtask

   initial begin
      rst           = 1'b1;
      bus.thread_en = 4'b1111;
      cyc();
      cyc();
      #1;
      chk("rst_valid", 32'(bus.fetch_valid), 32'd0);
      chk("rst_thread", 32'(bus.fetch_thread), 32'd0);
      chk("rst_pc", bus.fetch_pc, 32'h0000_1000);

      // All threads enabled, every fetch accepted.
      cyc(); rst = 1'b0; expect_fetch("rr0", 1'b1, 0, 32'h1000);
      cyc(); expect_fetch("rr1", 1'b1, 1, 32'h1000);
      cyc(); expect_fetch("rr2", 1'b1, 2, 32'h1000);
      cyc(); expect_fetch("rr3", 1'b1, 3, 32'h1000);
      cyc(); expect_fetch("rr4", 1'b1, 0, 32'h1004);

      // Mid-operation reset with a pending rejection must discard it.
      cyc(); rst = 1'b1; bus.hzu_isvalid = 1'b0; bus.thread_en = 4'b0001;
      expect_fetch("midrst", 1'b0, 0, 32'h0);

      // Lone thread issues every other cycle.
      cyc(); rst = 1'b0; expect_fetch("lone0", 1'b1, 0, 32'h1000);
      cyc(); expect_fetch("lone1", 1'b0, 0, 32'h0);
      cyc(); expect_fetch("lone2", 1'b1, 0, 32'h1004);
      cyc(); expect_fetch("lone3", 1'b0, 0, 32'h0);
      cyc(); expect_fetch("lone4", 1'b1, 0, 32'h1008);

      // I-cache miss parks T1 until its own fill completes.
      cyc(); rst = 1'b1; bus.thread_en = 4'b0010;
      cyc(); rst = 1'b0; bus.icache_miss = 1'b1; expect_fetch("fill_iss", 1'b1, 1, 32'h1000);
      cyc(); bus.hzu_isvalid = 1'b0; expect_fetch("fill_rej", 1'b0, 0, 32'h0);
      cyc(); expect_fetch("fill_park0", 1'b0, 0, 32'h0);
      cyc(); bus.fill_done = 1'b1; bus.fill_thread = 2'd0; expect_fetch("fill_park1", 1'b0, 0, 32'h0);
      cyc(); bus.fill_done = 1'b1; bus.fill_thread = 2'd1; expect_fetch("fill_park2", 1'b0, 0, 32'h0);
      cyc(); expect_fetch("fill_wake", 1'b1, 1, 32'h1000);

      // Both misses: I-TLB wins; a fill_done is ignored, tlb_done releases.
      cyc(); expect_fetch("tlb_gap", 1'b0, 0, 32'h0);
      cyc(); bus.itlb_miss = 1'b1; bus.icache_miss = 1'b1; expect_fetch("tlb_iss", 1'b1, 1, 32'h1004);
      cyc(); bus.hzu_isvalid = 1'b0; expect_fetch("tlb_rej", 1'b0, 0, 32'h0);
      cyc(); bus.fill_done = 1'b1; bus.fill_thread = 2'd1; expect_fetch("tlb_park0", 1'b0, 0, 32'h0);
      cyc(); bus.tlb_done = 1'b1; bus.tlb_thread = 2'd1; expect_fetch("tlb_park1", 1'b0, 0, 32'h0);
      cyc(); expect_fetch("tlb_wake", 1'b1, 1, 32'h1004);

      // Rejection with no recorded miss replays the same PC.
      cyc(); expect_fetch("rep_gap", 1'b0, 0, 32'h0);
      cyc(); expect_fetch("rep_iss", 1'b1, 1, 32'h1008);
      cyc(); bus.hzu_isvalid = 1'b0; expect_fetch("rep_rej", 1'b0, 0, 32'h0);
      cyc(); expect_fetch("rep_again", 1'b1, 1, 32'h1008);
      cyc(); expect_fetch("rep_gap2", 1'b0, 0, 32'h0);
      cyc(); expect_fetch("rep_next", 1'b1, 1, 32'h100C);

      // Redirect beats a same-cycle icache-miss rewind of T2.
      cyc(); rst = 1'b1; bus.thread_en = 4'b0100;
      cyc(); rst = 1'b0; bus.icache_miss = 1'b1; expect_fetch("redir_iss", 1'b1, 2, 32'h1000);
      cyc(); bus.hzu_isvalid = 1'b0; bus.redirect_valid = 1'b1;
      bus.redirect_thread = 2'd2; bus.redirect_pc = 32'h2000;
      expect_fetch("redir_rej", 1'b0, 0, 32'h0);
      cyc(); expect_fetch("redir_new", 1'b1, 2, 32'h2000);

      // Redirect to the top of the address space, then the increment wraps to zero.
      cyc(); bus.hzu_isvalid = 1'b0; bus.redirect_valid = 1'b1;
      bus.redirect_thread = 2'd2; bus.redirect_pc = 32'hFFFF_FFFC;
      expect_fetch("wrap_redir", 1'b0, 0, 32'h0);
      cyc(); expect_fetch("wrap_top", 1'b1, 2, 32'hFFFF_FFFC);
      cyc(); expect_fetch("wrap_gap", 1'b0, 0, 32'h0);
      cyc(); expect_fetch("wrap_zero", 1'b1, 2, 32'h0000_0000);

      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
